// File: rtl/i_cache_v2.sv
// i_cache_v2 -- direct-mapped, line-based instruction cache.
//
// Sits between the core fetch stage and the cache/memory controller.
// Misaligned or out-of-window fetches return a fault one cycle later.
// Hits return the cached word one cycle later. A miss refills the whole line
// through a request/grant handshake followed by LINE_WORDS data beats, then
// answers the original fetch.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   fetch_req/addr/ready             fetch request; accepted while fetch_ready=1
//   fetch_valid/data/fault           one-cycle response; fault[0]=misaligned,
//                                    fault[1]=out-of-bounds, data=0 on fault
//   mem_req/addr/gnt                 line refill request handshake
//   mem_rvalid/rdata                 refill beats, word 0 first
//   flush                            invalidate every line
//   set_*_addr, *_addr_we, get_*     fetch window (base/bound, inclusive)
//   hit_count, miss_count            saturating performance counters
module i_cache_v2 #(
    parameter int                ADDR_W     = 32,
    parameter int                NUM_LINES  = 64,
    parameter int                LINE_WORDS = 4,
    parameter logic [ADDR_W-1:0] BASE_RST   = '0,
    parameter logic [ADDR_W-1:0] BOUND_RST  = ADDR_W'(1024)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    output logic [1:0]        fetch_fault,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              flush,
    input  logic [ADDR_W-1:0] set_base_addr,
    input  logic [ADDR_W-1:0] set_bound_addr,
    input  logic              base_addr_we,
    input  logic              bound_addr_we,
    output logic [ADDR_W-1:0] get_base_addr,
    output logic [ADDR_W-1:0] get_bound_addr,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_DATA, RESP} state_t;

    // Miss being serviced; held from acceptance until the response.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] word;
    } req_t;

    state_t state_q, state_d;
    req_t   req_q;

    logic [LINE_WORDS-1:0][31:0] data_q [NUM_LINES];
    logic [TAG_W-1:0]            tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]        valid_q;

    logic [ADDR_W-1:0] base_q, bound_q;
    logic [WORD_W-1:0] beat_q;
    logic [31:0]       cap_q;
    logic              flush_pend_q;

    logic [WORD_W-1:0] f_word;
    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic              misaligned, out_of_bounds, tag_hit;
    logic              accept, take_hit, take_miss, last_beat;

    assign f_word = fetch_addr[OFF_W-1:2];
    assign f_idx  = fetch_addr[OFF_W+IDX_W-1:OFF_W];
    assign f_tag  = fetch_addr[ADDR_W-1:OFF_W+IDX_W];

    assign misaligned    = fetch_addr[1:0] != 2'b00;
    assign out_of_bounds = (fetch_addr < base_q) || (fetch_addr > bound_q);
    assign tag_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign accept        = fetch_req && (state_q == IDLE);
    // A same-cycle flush wins over the lookup, so the fetch becomes a miss.
    assign take_hit      = accept && !misaligned && !out_of_bounds && tag_hit && !flush;
    assign take_miss     = accept && !misaligned && !out_of_bounds && !(tag_hit && !flush);
    assign last_beat     = mem_rvalid && (beat_q == LAST_WORD);

    assign get_base_addr  = base_q;
    assign get_bound_addr = bound_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (take_miss) state_d = REFILL_REQ;
            REFILL_REQ:  if (mem_gnt)   state_d = REFILL_DATA;
            REFILL_DATA: if (last_beat) state_d = RESP;
            RESP:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fetch_ready = (state_q == IDLE) && !rst;
        mem_req     = (state_q == REFILL_REQ);
    end

    // ---------------- control / datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid  <= 1'b0;
            fetch_data   <= '0;
            fetch_fault  <= '0;
            mem_addr     <= '0;
            valid_q      <= '0;
            base_q       <= BASE_RST;
            bound_q      <= BOUND_RST;
            hit_count    <= '0;
            miss_count   <= '0;
            beat_q       <= '0;
            cap_q        <= '0;
            flush_pend_q <= 1'b0;
            req_q        <= '0;
        end else begin
            fetch_valid <= 1'b0;

            // Window writes are live immediately; a miss already in flight
            // was checked at acceptance and is not re-evaluated.
            if (base_addr_we)  base_q  <= set_base_addr;
            if (bound_addr_we) bound_q <= set_bound_addr;

            case (state_q)
                IDLE: begin
                    beat_q       <= '0;
                    flush_pend_q <= 1'b0;
                    if (flush) valid_q <= '0;
                    if (accept) begin
                        if (misaligned) begin
                            fetch_valid <= 1'b1;
                            fetch_fault <= 2'b01;
                            fetch_data  <= '0;
                        end else if (out_of_bounds) begin
                            fetch_valid <= 1'b1;
                            fetch_fault <= 2'b10;
                            fetch_data  <= '0;
                        end else if (take_hit) begin
                            fetch_valid <= 1'b1;
                            fetch_fault <= 2'b00;
                            fetch_data  <= data_q[f_idx][f_word];
                            hit_count   <= sat_inc(hit_count);
                        end else begin
                            req_q      <= '{tag: f_tag, idx: f_idx, word: f_word};
                            mem_addr   <= {fetch_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            miss_count <= sat_inc(miss_count);
                        end
                    end
                end
                REFILL_REQ: begin
                    if (flush) flush_pend_q <= 1'b1;
                end
                REFILL_DATA: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (mem_rvalid) begin
                        beat_q <= beat_q + 1'b1;
                        // Keep the requested word so the response does not need
                        // a second array read after the line lands.
                        if (beat_q == req_q.word) cap_q <= mem_rdata;
                        if (beat_q == LAST_WORD) begin
                            valid_q[req_q.idx] <= 1'b1;
                            fetch_valid        <= 1'b1;
                            fetch_fault        <= 2'b00;
                            fetch_data         <= (req_q.word == LAST_WORD) ? mem_rdata : cap_q;
                        end
                    end
                end
                RESP: begin
                    // Deferred flush lands on the way back to IDLE, so it also
                    // drops the line that was just filled.
                    if (flush || flush_pend_q) valid_q <= '0;
                    flush_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- line storage (no reset; guarded by valid_q) ----------------
    always_ff @(posedge clk) begin
        if (!rst && state_q == REFILL_DATA && mem_rvalid) begin
            data_q[req_q.idx][beat_q] <= mem_rdata;
            if (beat_q == LAST_WORD) tag_q[req_q.idx] <= req_q.tag;
        end
    end

endmodule

// File: tb/tb_i_cache_v2.sv
// Directed bench for i_cache_v2. Stimulus pushes the expected fetch response
// into a scoreboard queue; an independent monitor pops and compares whenever
// fetch_valid is seen. Memory word at byte address a is 0xD000_0000 | a.
module tb_i_cache_v2;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ready, fetch_valid;
    logic [31:0] fetch_data;
    logic [1:0]  fetch_fault;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        flush = 1'b0;
    logic [31:0] set_base_addr = '0, set_bound_addr = '0;
    logic        base_addr_we = 1'b0, bound_addr_we = 1'b0;
    logic [31:0] get_base_addr, get_bound_addr, hit_count, miss_count;

    i_cache_v2 dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .set_base_addr(set_base_addr), .set_bound_addr(set_bound_addr),
        .base_addr_we(base_addr_we), .bound_addr_we(bound_addr_we),
        .get_base_addr(get_base_addr), .get_bound_addr(get_bound_addr),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fault;
        int          due;   // expected cycle of the response, -1 = not checked
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every fetch_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (fetch_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: data %h fault %b with empty scoreboard", fetch_data, fetch_fault);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data", fetch_data, e.data);
                chk("resp_fault", 32'(fetch_fault), 32'(e.fault));
                if (e.due >= 0) chk("resp_latency", cyc, e.due);
            end
        end
    end

    function automatic logic [31:0] mword(input logic [31:0] a);
        return 32'hD000_0000 | a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one fetch for one cycle; calling again straight away keeps
    // fetch_req high, giving back-to-back requests.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] f, input bit timed);
        int n = 0;
        while (fetch_ready !== 1'b1 && n < 100) begin tick(); n++; end
        if (fetch_ready !== 1'b1) chk("ready_timeout", 32'(fetch_ready), 32'd1);
        fetch_req  = 1'b1;
        fetch_addr = a;
        sb.push_back('{data: d, fault: f, due: timed ? cyc + 1 : -1});
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fetch_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("idle_reached", 32'(fetch_ready), 32'd1);
    endtask

    // Memory side of a refill: grant after gdly cycles, LW beats with one
    // idle gap before beat 2. flush_b / rst_b pick a beat to pulse flush / rst on.
    task automatic refill(input logic [31:0] line, input int gdly, input int flush_b, input int rst_b);
        chk("mem_req_on_miss", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, line);
        repeat (gdly) tick();
        chk("mem_req_held", 32'(mem_req), 32'd1);
        chk("mem_addr_held", mem_addr, line);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("mem_req_drop", 32'(mem_req), 32'd0);
        for (int b = 0; b < LW; b++) begin
            if (b == 2) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = mword(line + 32'(4 * b));
            flush      = (b == flush_b);
            rst        = (b == rst_b);
            tick();
            mem_rvalid = 1'b0;
            flush      = 1'b0;
            if (b == rst_b) begin
                chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
                chk("rst_fetch_data", fetch_data, 32'd0);
                chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
                chk("rst_mem_req", 32'(mem_req), 32'd0);
                chk("rst_mem_addr", mem_addr, 32'd0);
                chk("rst_ready_low", 32'(fetch_ready), 32'd0);
                chk("rst_hit_count", hit_count, 32'd0);
                chk("rst_miss_count", miss_count, 32'd0);
                chk("rst_bound", get_bound_addr, 32'd1024);
                rst = 1'b0;
                void'(sb.pop_back());   // abandoned miss never answers
                return;
            end
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("reset_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("reset_fetch_data", fetch_data, 32'd0);
        chk("reset_fetch_fault", 32'(fetch_fault), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_ready_in_rst", 32'(fetch_ready), 32'd0);
        chk("reset_base", get_base_addr, 32'd0);
        chk("reset_bound", get_bound_addr, 32'd1024);
        chk("reset_hits", hit_count, 32'd0);
        chk("reset_misses", miss_count, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(fetch_ready), 32'd1);

        // Cold miss on 0x0, grant after 2 cycles
        issue(32'h0, 32'hD000_0000, 2'b00, 1'b0);
        refill(32'h0, 2, -1, -1);
        wait_idle();
        chk("miss_count_1", miss_count, 32'd1);
        chk("hit_count_0", hit_count, 32'd0);

        // Back-to-back hits in the same line
        issue(32'h4, 32'hD000_0004, 2'b00, 1'b1);
        issue(32'h8, 32'hD000_0008, 2'b00, 1'b1);
        issue(32'hC, 32'hD000_000C, 2'b00, 1'b1);
        chk("hits_no_mem_req", 32'(mem_req), 32'd0);
        tick();
        chk("hit_count_3", hit_count, 32'd3);

        // Misaligned, then out-of-bounds above a shrunken bound
        issue(32'h6, 32'h0, 2'b01, 1'b1);
        chk("misalign_no_mem_req", 32'(mem_req), 32'd0);
        set_bound_addr = 32'hFF;
        bound_addr_we  = 1'b1;
        tick();
        bound_addr_we = 1'b0;
        chk("bound_written", get_bound_addr, 32'hFF);
        issue(32'h100, 32'h0, 2'b10, 1'b1);
        chk("oob_no_mem_req", 32'(mem_req), 32'd0);
        // Bound is inclusive: 0xFC is inside and misses (word 3 of line 0xF0)
        issue(32'hFC, 32'hD000_00FC, 2'b00, 1'b0);
        refill(32'hF0, 0, -1, -1);
        wait_idle();
        chk("miss_count_2", miss_count, 32'd2);

        // Both window registers in one cycle; below-base faults, base itself is in
        set_base_addr  = 32'h8;
        set_bound_addr = 32'h7FF;
        base_addr_we   = 1'b1;
        bound_addr_we  = 1'b1;
        tick();
        base_addr_we  = 1'b0;
        bound_addr_we = 1'b0;
        chk("base_both_we", get_base_addr, 32'h8);
        chk("bound_both_we", get_bound_addr, 32'h7FF);
        issue(32'h4, 32'h0, 2'b10, 1'b1);
        issue(32'h8, 32'hD000_0008, 2'b00, 1'b1);
        set_base_addr = 32'h0;
        base_addr_we  = 1'b1;
        tick();
        base_addr_we = 1'b0;
        chk("base_only_we", get_base_addr, 32'h0);
        chk("bound_kept", get_bound_addr, 32'h7FF);
        chk("counts_after_faults_hit", hit_count, 32'd4);

        // Aliasing: 0x400 shares index 0 with 0x0
        issue(32'h0, 32'hD000_0000, 2'b00, 1'b1);
        issue(32'h400, 32'hD000_0400, 2'b00, 1'b0);
        refill(32'h400, 1, -1, -1);
        wait_idle();
        issue(32'h0, 32'hD000_0000, 2'b00, 1'b0);
        refill(32'h0, 0, -1, -1);
        wait_idle();
        chk("alias_misses", miss_count, 32'd4);
        chk("alias_hits", hit_count, 32'd5);

        // Flush during beat 2: response still delivered, line then misses
        issue(32'h24, 32'hD000_0024, 2'b00, 1'b0);
        refill(32'h20, 0, 2, -1);
        wait_idle();
        issue(32'h2C, 32'hD000_002C, 2'b00, 1'b0);
        refill(32'h20, 0, -1, -1);
        wait_idle();
        // Flush in IDLE alongside a fetch that would hit: treated as a miss
        flush = 1'b1;
        issue(32'h20, 32'hD000_0020, 2'b00, 1'b0);
        flush = 1'b0;
        refill(32'h20, 0, -1, -1);
        wait_idle();
        chk("flush_misses", miss_count, 32'd7);
        chk("flush_hits", hit_count, 32'd5);

        // Reset in the middle of REFILL_DATA
        issue(32'h40, 32'hD000_0040, 2'b00, 1'b0);
        refill(32'h40, 0, -1, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        repeat (3) tick();
        mem_rvalid = 1'b0;
        chk("stray_no_mem_req", 32'(mem_req), 32'd0);
        chk("stray_ready", 32'(fetch_ready), 32'd1);
        issue(32'h40, 32'hD000_0040, 2'b00, 1'b0);
        refill(32'h40, 0, -1, -1);
        wait_idle();
        chk("post_reset_miss", miss_count, 32'd1);
        chk("post_reset_hits", hit_count, 32'd0);

        tick();
        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
